// File: rtl/lc3_mem_arbiter.sv
// Arbitrates one single-port unified memory between the LC3 fetch and data ports.
// Data has priority; a fetch is forced through after STARVE_MAX consecutive data grants.
module lc3_mem_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instrmem_rd,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] Instr_dout,
   output logic              complete_instr,
   input  logic              data_req,
   input  logic              Data_rd,
   input  logic [ADDR_W-1:0] Data_addr,
   input  logic [DATA_W-1:0] Data_din,
   output logic [DATA_W-1:0] Data_dout,
   output logic              complete_data,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
   localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D, DONE_I, DONE_D
   } state_t;

   state_t            state_q, state_d;
   logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              is_write_q, is_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] instr_dout_q, instr_dout_d;
   logic [DATA_W-1:0] data_dout_q, data_dout_d;

   logic              force_instr;

   assign force_instr = (starve_cnt_q == SC_W'(STARVE_MAX));

   always_comb begin
      state_d        = state_q;
      starve_cnt_d   = starve_cnt_q;
      wait_cnt_d     = wait_cnt_q;
      is_write_d     = is_write_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      instr_dout_d   = instr_dout_q;
      data_dout_d    = data_dout_q;
      mem_en         = 1'b0;
      mem_we         = 1'b0;
      complete_instr = 1'b0;
      complete_data  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!instrmem_rd) begin
               starve_cnt_d = '0;
            end
            if (data_req && !(instrmem_rd && force_instr)) begin
               state_d    = ISSUE_D;
               mem_addr_d = Data_addr;
               is_write_d = !Data_rd;
               if (!Data_rd) begin
                  mem_wdata_d = Data_din;
               end
               if (instrmem_rd && !force_instr) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
               end
            end else if (instrmem_rd) begin
               state_d      = ISSUE_I;
               mem_addr_d   = pc;
               is_write_d   = 1'b0;
               starve_cnt_d = '0;
            end
         end
         // Both latencies route through WAIT so mem_rdata is always sampled MEM_LAT cycles after mem_en.
         ISSUE_I: begin
            mem_en     = 1'b1;
            wait_cnt_d = CNT_W'(MEM_LAT - 1);
            state_d    = WAIT_I;
         end
         ISSUE_D: begin
            mem_en     = 1'b1;
            mem_we     = is_write_q;
            wait_cnt_d = CNT_W'(MEM_LAT - 1);
            state_d    = WAIT_D;
         end
         WAIT_I: begin
            if (wait_cnt_q == '0) begin
               instr_dout_d = mem_rdata;
               state_d      = DONE_I;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         WAIT_D: begin
            if (wait_cnt_q == '0) begin
               if (!is_write_q) begin
                  data_dout_d = mem_rdata;
               end
               state_d = DONE_D;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         DONE_I: begin
            complete_instr = 1'b1;
            state_d        = IDLE;
         end
         DONE_D: begin
            complete_data = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         wait_cnt_q   <= '0;
         is_write_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         instr_dout_q <= '0;
         data_dout_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         is_write_q   <= is_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         instr_dout_q <= instr_dout_d;
         data_dout_q  <= data_dout_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign Instr_dout = instr_dout_q;
   assign Data_dout  = data_dout_q;

endmodule
